vote_report_tx: RTL and testbench
=================================

Name: vote_report_tx

Overview:
- Serial readout of the eight per-candidate vote totals produced by the vote counter, for an external logger or PC.
- On an authorised start request it snapshots all eight 14-bit totals and converts each to 4-digit decimal ASCII.
- It then transmits a fixed 72-byte UART 8N1 report.
- Sits beside the display path and consumes the same totals; it is read-only and never modifies the counts.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200).
- MODE_KEY, 25, mode value that authorises a report (same password as result mode).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  report request, level sampled each cycle
- mode  in  5  mode/password switches
- totals  in  112  packed totals: cand1 = [13:0], cand2 = [27:14], ... cand8 = [111:98]
- tx  out  1  UART serial line, idle high
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse at report completion

Behaviour:
- Reset values: tx=1, busy=0, done=0; FSM in IDLE; all internal counters cleared. Reset mid-report aborts at once: tx returns high the next cycle, partial byte is abandoned, no done pulse.
- Accept: in IDLE, start=1 AND mode==MODE_KEY on a clk edge → acceptance. In that same edge, all eight totals are snapshotted, and the FSM moves to CONV with busy=1 from the next cycle.
- Ignored starts: any start while busy, and any start with mode!=MODE_KEY. Neither causes an effect or an error.
- Snapshot rule: changes to totals or mode after acceptance do not affect the report in progress.
- CONV: lasts exactly 16 cycles, with tx held high.
  - Binary-to-BCD conversion of the 8 snapshot values, e.g. parallel double-dabble, 14 shift steps plus overhead.
  - Saturation: any value >9999 is reported as 9999.
- SEND: 72 bytes back-to-back with no idle gap. The next start bit immediately follows the previous stop bit.
- Record k (k=1..8) is 9 bytes: 'C'(0x43), ASCII k (0x31..0x38), ':'(0x3A), four decimal digits MSD first with leading zeros kept (0x30..0x39), CR(0x0D), LF(0x0A).
- UART framing: 8N1, LSB first.
  - Each bit is held exactly CLKS_PER_BIT cycles: start=0, 8 data bits, stop=1.
  - The start bit of byte 1 begins on the 17th cycle after the acceptance edge.
- DONE: after the final stop bit's last cycle, done=1 for exactly one cycle and busy=0 in that same cycle; the FSM returns to IDLE.
  - A start held high can be accepted again on the cycle after done.
- Total latency, acceptance edge to done: 16 + 720·CLKS_PER_BIT cycles.
- Internal widths: the bit-timer must hold CLKS_PER_BIT−1, the byte index counts 0..71, and the bit index counts 0..9. No counter may wrap within a report.
- States: IDLE → CONV → SEND → DONE → IDLE. No other transitions except reset.

Test Plan (CLKS_PER_BIT=4):
- Totals cand1=7, cand2=1234, others 0; mode=25; 1-cycle start.
  - Required: 72 bytes decoded, starting "C1:0007\r\nC2:1234\r\nC3:0000\r\n" ... "C8:0000\r\n".
  - Required: tx first falls 17 cycles after acceptance.
  - Required: done pulse at cycle 16+2880 after acceptance; busy=0 in that cycle.
- cand5=12000 (>9999), cand8=9999 → records "C5:9999" and "C8:9999".
- start=1 with mode=24 for 100 cycles → tx stays 1, busy stays 0, no done.
- Start accepted, then cand1 changed 0→55 and mode changed to 0 during SEND → report still shows "C1:0000" and completes normally. A second start pulse mid-report is ignored, giving exactly one done.
- Reset asserted mid-byte 10 → next cycle tx=1, busy=0, no done. A fresh start afterwards yields a complete, correct 72-byte report.
- start held high continuously with mode=25 → back-to-back reports. Next acceptance occurs on the cycle after done, and tx stays high for exactly 16 CONV cycles before the next start bit.

Source files
------------

// File: rtl/vote_report_tx.sv
// Snapshots the eight vote totals on an authorised request and sends them as a fixed
// 72-byte ASCII report ("Ck:dddd\r\n" x8) over a UART 8N1 line.
module vote_report_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int MODE_KEY     = 25
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [4:0]   mode,
   input  logic [111:0] totals,
   output logic         tx,
   output logic         busy,
   output logic         done
);

   localparam int           TW    = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 2);
   localparam logic [4:0]   KEY   = 5'(MODE_KEY);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [3:0]    conv_q, conv_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    bit_q, bit_d;
   logic [6:0]    byte_q, byte_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          tx_q, tx_d;
   logic          accept;
   logic [6:0]    rec_w, pos_w;
   logic [7:0]    ch_w;
   // {bcd[15:0], binary[13:0]} working register per candidate
   logic [29:0]   dd_q [8];

   function automatic logic [13:0] sat14(input logic [13:0] v);
      return (v > 14'd9999) ? 14'd9999 : v;
   endfunction

   function automatic logic [29:0] dabble(input logic [29:0] v);
      logic [29:0] r;
      r = v;
      for (int k = 0; k < 4; k++) begin
         if (r[14+4*k +: 4] >= 4'd5) r[14+4*k +: 4] = r[14+4*k +: 4] + 4'd3;
      end
      return r << 1;
   endfunction

   function automatic logic [7:0] report_char(input logic [6:0] pos, input logic [6:0] rec,
                                              input logic [15:0] bcd);
      case (pos)
         7'd0:    return 8'h43;
         7'd1:    return 8'h31 + {1'b0, rec};
         7'd2:    return 8'h3A;
         7'd3:    return 8'h30 + {4'h0, bcd[15:12]};
         7'd4:    return 8'h30 + {4'h0, bcd[11:8]};
         7'd5:    return 8'h30 + {4'h0, bcd[7:4]};
         7'd6:    return 8'h30 + {4'h0, bcd[3:0]};
         7'd7:    return 8'h0D;
         default: return 8'h0A;
      endcase
   endfunction

   assign accept = (state_q == S_IDLE) && start && (mode == KEY);

   always_comb begin
      state_d = state_q;
      conv_d  = conv_q;
      timer_d = timer_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_CONV;
               conv_d  = '0;
               busy_d  = 1'b1;
            end
         end
         S_CONV: begin
            if (conv_q == 4'd15) begin
               state_d = S_SEND;
               timer_d = '0;
               bit_d   = '0;
               byte_d  = '0;
            end else begin
               conv_d = conv_q + 4'd1;
            end
         end
         S_SEND: begin
            // DONE covers the last cycle of the final stop bit, so done lands right after it
            if (byte_q == 7'd71 && bit_q == 4'd9 && timer_q == TLAST) state_d = S_DONE;
            if (timer_q == TMAX) begin
               timer_d = '0;
               if (bit_q == 4'd9) begin
                  bit_d  = '0;
                  byte_d = byte_q + 7'd1;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
      endcase

      rec_w = byte_d / 7'd9;
      pos_w = byte_d % 7'd9;
      ch_w  = report_char(pos_w, rec_w, dd_q[rec_w[2:0]][29:14]);
      tx_d  = 1'b1;
      if (state_d == S_SEND) begin
         case (bit_d)
            4'd0:    tx_d = 1'b0;
            4'd9:    tx_d = 1'b1;
            default: tx_d = ch_w[bit_d[2:0] - 3'd1];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         conv_q  <= '0;
         timer_q <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         conv_q  <= conv_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tx_q    <= tx_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (accept) dd_q[i] <= {16'h0000, sat14(totals[14*i +: 14])};
         else if (state_q == S_CONV && conv_q < 4'd14) dd_q[i] <= dabble(dd_q[i]);
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_vote_report_tx.sv
// Bench for vote_report_tx: expected report bytes are queued at each request and
// compared against bytes decoded from the UART line.
module tb_vote_report_tx;

   localparam int CPB = 4;

   logic         clk;
   logic         reset;
   logic         start;
   logic [4:0]   mode;
   logic [111:0] totals;
   logic         tx;
   logic         busy;
   logic         done;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   vote_report_tx #(.CLKS_PER_BIT(CPB), .MODE_KEY(25)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .totals(totals),
      .tx(tx), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic set_cand(input int k, input int v);
      totals[14*(k-1) +: 14] = 14'(v);
   endtask

   task automatic push_report(input logic [111:0] t);
      int v;
      for (int k = 0; k < 8; k++) begin
         v = int'(t[14*k +: 14]);
         if (v > 9999) v = 9999;
         exp_q.push_back(8'h43);
         exp_q.push_back(8'(49 + k));
         exp_q.push_back(8'h3A);
         exp_q.push_back(8'(48 + v / 1000));
         exp_q.push_back(8'(48 + (v / 100) % 10));
         exp_q.push_back(8'(48 + (v / 10) % 10));
         exp_q.push_back(8'(48 + v % 10));
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   // UART receiver: start bit detected on its first cycle, bits sampled on their 2nd cycle
   initial begin : uart_mon
      logic [7:0] b;
      logic       ab;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!reset && tx === 1'b0) begin
            b  = 8'h00;
            ab = 1'b0;
            for (int i = 1; i <= 37 && !ab; i++) begin
               @(negedge clk);
               if (reset) ab = 1'b1;
               else if (i >= 5 && i <= 33 && ((i - 5) % 4) == 0) b = {tx, b[7:1]};
            end
            if (!ab) begin
               check("stop_bit", 32'(tx), 32'd1);
               if (exp_q.size() == 0) begin
                  check("extra_byte", 32'(exp_q.size()), 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  check("rx_byte", 32'(b), 32'(e));
               end
            end
         end
      end
   end

   // One report from a 1-cycle start; disturb alters inputs mid-report, abort_at asserts reset
   task automatic run_report(input bit disturb, input int abort_at);
      int n, first_low, done_at, dones;
      push_report(totals);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      first_low = -1;
      done_at   = -1;
      dones     = 0;
      for (n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (n == 0) begin
            check("busy_after_accept", 32'(busy), 32'd1);
            check("tx_high_conv", 32'(tx), 32'd1);
         end
         if (first_low < 0 && tx === 1'b0) first_low = n;
         if (done === 1'b1) begin
            dones++;
            if (done_at < 0) begin
               done_at = n;
               check("busy_at_done", 32'(busy), 32'd0);
            end
         end
         if (disturb) begin
            if (n == 20) begin
               set_cand(1, 55);
               mode = 5'd0;
            end
            if (n == 800) begin
               mode  = 5'd25;
               start = 1'b1;
            end
            if (n == 801) start = 1'b0;
         end
         if (abort_at > 0) begin
            if (n == abort_at) reset = 1'b1;
            if (n == abort_at + 1) begin
               check("abort_tx", 32'(tx), 32'd1);
               check("abort_busy", 32'(busy), 32'd0);
               check("abort_done", 32'(done), 32'd0);
            end
            if (n == abort_at + 2) reset = 1'b0;
         end
      end
      if (abort_at > 0) begin
         check("abort_no_done", 32'(dones), 32'd0);
         check("abort_idle_busy", 32'(busy), 32'd0);
         exp_q.delete();
      end else begin
         check("first_start_bit", 32'(first_low), 32'd16);
         check("done_cycle", 32'(done_at), 32'(16 + 720 * CPB));
         check("done_count", 32'(dones), 32'd1);
         check("all_bytes_seen", 32'(exp_q.size()), 32'd0);
      end
   endtask

   task automatic back_to_back();
      int n, d1, d2, dones, low2, busy_next;
      push_report(totals);
      push_report(totals);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk);
      d1 = -1; d2 = -1; dones = 0; low2 = -1; busy_next = -1;
      for (n = 0; n < 5900; n++) begin
         @(negedge clk);
         if (d1 >= 0 && n == d1 + 1) busy_next = int'(busy);
         if (d1 >= 0 && low2 < 0 && tx === 1'b0) low2 = n;
         if (done === 1'b1) begin
            dones++;
            if (d1 < 0) d1 = n;
            else if (d2 < 0) begin
               d2 = n;
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      check("b2b_done1", 32'(d1), 32'(16 + 720 * CPB));
      check("b2b_busy_next", 32'(busy_next), 32'd1);
      check("b2b_conv_gap", 32'(low2 - d1), 32'd17);
      check("b2b_done2", 32'(d2), 32'(2 * (16 + 720 * CPB) + 1));
      check("b2b_done_count", 32'(dones), 32'd2);
      check("b2b_final_busy", 32'(busy), 32'd0);
      check("b2b_all_bytes", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int txlow, busyhi, donehi;
      reset  = 1'b1;
      start  = 1'b0;
      mode   = 5'd25;
      totals = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(posedge clk);

      totals = '0;
      set_cand(1, 7);
      set_cand(2, 1234);
      run_report(1'b0, 0);

      totals = '0;
      set_cand(5, 12000);
      set_cand(8, 9999);
      set_cand(3, 10000);
      run_report(1'b0, 0);

      mode = 5'd24;
      @(posedge clk); #1 start = 1'b1;
      txlow = 0; busyhi = 0; donehi = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) txlow++;
         if (busy !== 1'b0) busyhi++;
         if (done !== 1'b0) donehi++;
      end
      start = 1'b0;
      check("badkey_tx_low", 32'(txlow), 32'd0);
      check("badkey_busy", 32'(busyhi), 32'd0);
      check("badkey_done", 32'(donehi), 32'd0);
      mode = 5'd25;

      totals = '0;
      set_cand(4, 321);
      run_report(1'b1, 0);
      mode = 5'd25;

      totals = '0;
      set_cand(3, 42);
      set_cand(6, 9000);
      run_report(1'b0, 16 + 9 * 10 * CPB + 15);
      repeat (5) @(posedge clk);
      run_report(1'b0, 0);

      totals = '0;
      set_cand(2, 8765);
      set_cand(7, 100);
      back_to_back();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
